// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of an asynchronous PWM input in clk
// cycles, strobes one measurement per full period and flags a stuck-high/low input.
module pwm_capture #(
   parameter int N       = 32,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pwm_in,
   output logic [N-1:0] period_out,
   output logic [N-1:0] high_out,
   output logic         meas_valid,
   output logic         stuck_high,
   output logic         stuck_low
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [N-1:0] ZERO    = {N{1'b0}};
   localparam logic [N-1:0] ONE     = N'(1);
   localparam logic [N-1:0] TO_FULL = N'(TIMEOUT);
   localparam logic [N-1:0] TO_LAST = N'(TIMEOUT - 1);

   logic         sync1_r;
   logic         sync2_r;
   logic         prev_r;
   logic [N-1:0] cnt_r;
   logic [N-1:0] high_lat_r;
   state_t       state_r;

   logic         rise_s;
   logic         fall_s;
   logic         tmo_s;

   // Edge decode; a detected edge in the same cycle overrides the timeout.
   always_comb begin
      rise_s = sync2_r & ~prev_r;
      fall_s = ~sync2_r & prev_r;
      tmo_s  = (cnt_r == TO_LAST) & ~rise_s;
   end

   // Two-stage synchronizer plus one delay stage, so both edges see equal latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= pwm_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Cycle counter restarted by each rising edge, saturating at TIMEOUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= ZERO;
      end else if (rise_s) begin
         cnt_r <= ONE;
      end else if (cnt_r != TO_FULL) begin
         cnt_r <= cnt_r + ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Measurement FSM with registered results and stuck flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         high_lat_r <= ZERO;
         period_out <= ZERO;
         high_out   <= ZERO;
         meas_valid <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (rise_s) begin
                  stuck_high <= 1'b0;
                  stuck_low  <= 1'b0;
                  state_r    <= HIGH;
               end else if (tmo_s) begin
                  stuck_high <= sync2_r;
                  stuck_low  <= ~sync2_r;
               end else begin
                  state_r <= IDLE;
               end
            end
            HIGH: begin
               if (fall_s) begin
                  high_lat_r <= cnt_r;
                  state_r    <= LOW;
               end else if (tmo_s) begin
                  stuck_high <= 1'b1;
                  stuck_low  <= 1'b0;
                  period_out <= ZERO;
                  high_out   <= ZERO;
                  state_r    <= IDLE;
               end else begin
                  state_r <= HIGH;
               end
            end
            LOW: begin
               if (rise_s) begin
                  period_out <= cnt_r;
                  high_out   <= high_lat_r;
                  meas_valid <= 1'b1;
                  state_r    <= HIGH;
               end else if (tmo_s) begin
                  stuck_low  <= 1'b1;
                  stuck_high <= 1'b0;
                  period_out <= ZERO;
                  high_out   <= ZERO;
                  state_r    <= IDLE;
               end else begin
                  state_r <= LOW;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: reset, steady PWM, duty step, stuck low/high,
// minimum-width input and reset in the middle of a high phase.
module tb_pwm_capture;

   localparam int N   = 32;
   localparam int TMO = 8000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pwm_in;
   logic [N-1:0] period_out;
   logic [N-1:0] high_out;
   logic         meas_valid;
   logic         stuck_high;
   logic         stuck_low;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int n_dbl   = 0;
   logic mv_prev = 1'b0;
   int q_per[$];
   int q_hi[$];
   int q_cyc[$];

   pwm_capture #(.N(N), .TIMEOUT(TMO)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_in     (pwm_in),
      .period_out (period_out),
      .high_out   (high_out),
      .meas_valid (meas_valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   always #5 clk = ~clk;

   // Cycle stamp for strobe spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe recorder, sampled on the falling edge.
   always @(negedge clk) begin
      if (meas_valid) begin
         q_per.push_back(int'(period_out));
         q_hi.push_back(int'(high_out));
         q_cyc.push_back(cyc);
         if (mv_prev) n_dbl <= n_dbl + 1;
      end
      mv_prev <= meas_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pwm_periods(input int hi, input int lo, input int n);
      for (int k = 0; k < n; k++) begin
         pwm_in = 1'b1;
         repeat (hi) @(negedge clk);
         pwm_in = 1'b0;
         repeat (lo) @(negedge clk);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_per"},  period_out, 32'd0);
      chk({tag, "_hi"},   high_out,   32'd0);
      chk({tag, "_mv"},   {31'd0, meas_valid}, 32'd0);
      chk({tag, "_sh"},   {31'd0, stuck_high}, 32'd0);
      chk({tag, "_sl"},   {31'd0, stuck_low},  32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;

      // Input low since reset: stuck_low exactly TIMEOUT cycles later.
      repeat (TMO - 1) @(negedge clk);
      chk("sl_early", {31'd0, stuck_low}, 32'd0);
      @(negedge clk);
      chk("sl_set",  {31'd0, stuck_low},  32'd1);
      chk("sl_sh",   {31'd0, stuck_high}, 32'd0);
      chk("sl_per",  period_out, 32'd0);
      chk("sl_hi",   high_out,   32'd0);
      chk("sl_nstb", q_per.size(), 32'd0);

      // Period 6000 / high 1500, then duty step to 4500.
      q_per.delete(); q_hi.delete(); q_cyc.delete();
      pwm_periods(1500, 4500, 1);
      chk("p6k_first", q_per.size(), 32'd0);
      chk("p6k_slclr", {31'd0, stuck_low}, 32'd0);
      pwm_periods(1500, 4500, 2);
      pwm_periods(4500, 1500, 2);

      // Held high after the last rise: stuck_high TIMEOUT cycles after it.
      pwm_in = 1'b1;
      repeat (TMO + 1) @(negedge clk);
      chk("sh_early", {31'd0, stuck_high}, 32'd0);
      @(negedge clk);
      chk("sh_set", {31'd0, stuck_high}, 32'd1);
      chk("sh_sl",  {31'd0, stuck_low},  32'd0);
      chk("sh_per", period_out, 32'd0);
      chk("sh_hi",  high_out,   32'd0);

      chk("p6k_n", q_per.size(), 32'd5);
      for (int i = 0; i < q_per.size() && i < 5; i++) begin
         chk("p6k_per", q_per[i], 32'd6000);
         chk("p6k_hi",  q_hi[i],  (i < 3) ? 32'd1500 : 32'd4500);
         if (i > 0) chk("p6k_gap", q_cyc[i] - q_cyc[i-1], 32'd6000);
      end

      // A falling edge alone does not clear the flag.
      pwm_in = 1'b0;
      repeat (5) @(negedge clk);
      chk("sh_hold", {31'd0, stuck_high}, 32'd1);

      // Resume with the minimum 1-high/1-low input.
      q_per.delete(); q_hi.delete(); q_cyc.delete();
      for (int i = 0; i < 20; i++) begin
         pwm_in = 1'b1;
         @(negedge clk);
         if (i == 1) begin
            chk("alt_shclr", {31'd0, stuck_high}, 32'd0);
            chk("alt_nofirst", q_per.size(), 32'd0);
         end
         pwm_in = 1'b0;
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk("alt_n", q_per.size(), 32'd19);
      for (int i = 0; i < q_per.size(); i++) begin
         chk("alt_per", q_per[i], 32'd2);
         chk("alt_hi",  q_hi[i],  32'd1);
         if (i > 0) chk("alt_gap", q_cyc[i] - q_cyc[i-1], 32'd2);
      end
      chk("alt_dbl",     n_dbl,      32'd0);
      chk("hold_per",    period_out, 32'd2);
      chk("hold_hi",     high_out,   32'd1);
      chk("hold_mv",     {31'd0, meas_valid}, 32'd0);

      // High 3 / low 7, then reset in the middle of a high phase.
      pwm_periods(3, 7, 2);
      pwm_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("h3_per", period_out, 32'd10);
      chk("h3_hi",  high_out,   32'd3);
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("post_rst");
      q_per.delete(); q_hi.delete(); q_cyc.delete();
      pwm_periods(3, 7, 1);
      chk("pr_first", q_per.size(), 32'd0);
      pwm_periods(3, 7, 1);
      chk("pr_n", q_per.size(), 32'd1);
      if (q_per.size() > 0) begin
         chk("pr_per", q_per[0], 32'd10);
         chk("pr_hi",  q_hi[0],  32'd3);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
